// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
// Shared definitions for the nibble-serial adder:
//   NIBBLE_W    - width of one adder slice (always 4)
//   NIBBLES_DEF - default number of nibbles per operand
//   state_t     - control FSM state type (also exported on the debug port)
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W    = 4;
   localparam int NIBBLES_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_four_bit_adder.sv
// -----------------------------------------------------------------------------
// four_bit_adder
// Combinational 4-bit ripple slice: {c_out, sum} = x + y + c_in.
// Ports:
//   x, y   - 4-bit addends
//   c_in   - carry in
//   sum    - 4-bit result
//   c_out  - carry out
// -----------------------------------------------------------------------------
module four_bit_adder (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);

   logic [4:0] total;

   assign total = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};
   assign sum   = total[3:0];
   assign c_out = total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Adds two W-bit operands (W = 4*NIBBLES) one nibble per clock through a single
// four_bit_adder. An operand set is captured on the accept edge, NIBBLES RUN
// cycles follow, and the result is held in DONE until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE and, once
// high, stays high with stable sum/c_out/ovf until out_ready is seen.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   in_valid, in_ready - operand handshake (x, y, c_in)
//   x, y, c_in         - operands and carry into nibble 0
//   out_valid,out_ready- result handshake
//   sum, c_out, ovf    - result, carry out of top nibble, signed overflow
//   state_dbg          - current FSM state, for observation only
// -----------------------------------------------------------------------------
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] x,
   input  logic [NIBBLE_W*NIBBLES-1:0] y,
   input  logic                      c_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                      c_out,
   output logic                      ovf,
   output state_t                    state_dbg
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);

   state_t             state_q;
   state_t             state_d;

   logic [W-1:0]       x_q;
   logic [W-1:0]       y_q;
   logic               carry_q;
   logic [IDX_W-1:0]   idx_q;
   logic [W-1:0]       sum_q;
   logic               c_out_q;
   logic               ovf_q;

   logic [NIBBLE_W-1:0] a_nib;
   logic [NIBBLE_W-1:0] b_nib;
   logic [NIBBLE_W-1:0] nib_sum;
   logic                nib_carry;
   logic                last_nib;

   assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_RUN;
         ST_RUN:  if (last_nib)  state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Nibble select: a plain mux on the index, so no shifter or multiplier is
   // built for the slice position.
   // ---------------------------------------------------------------------------
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_nib = x_q[i*NIBBLE_W +: NIBBLE_W];
            b_nib = y_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   four_bit_adder u_adder (
      .x     (a_nib),
      .y     (b_nib),
      .c_in  (carry_q),
      .sum   (nib_sum),
      .c_out (nib_carry)
   );

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q     <= '0;
         y_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  x_q     <= x;
                  y_q     <= y;
                  carry_q <= c_in;
                  idx_q   <= '0;
               end
            end
            ST_RUN: begin
               for (int i = 0; i < NIBBLES; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     sum_q[i*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                  end
               end
               carry_q <= nib_carry;
               if (last_nib) begin
                  // The top slice result is the final sum MSB, so overflow is
                  // decided here from the captured operand MSBs.
                  idx_q   <= '0;
                  c_out_q <= nib_carry;
                  ovf_q   <= (x_q[W-1] == y_q[W-1]) &&
                             (nib_sum[NIBBLE_W-1] != x_q[W-1]);
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign sum       = sum_q;
   assign c_out     = c_out_q;
   assign ovf       = ovf_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Directed vectors and multi-cycle sequences on a NIBBLES=4 instance, plus
// randomized traffic on NIBBLES=2, 4 and 8 instances checked against plain
// integer arithmetic.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;
   import nibble_serial_adder_pkg::*;

   // ---------------------------------------------------------------------------
   // Clock / shared counters
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int errors   = 0;
   int rand_fin = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Directed DUT (NIBBLES = 4)
   // ---------------------------------------------------------------------------
   logic        d_rst, d_iv, d_ir, d_ov, d_or, d_ci, d_co, d_of;
   logic [15:0] d_x, d_y, d_s;
   state_t      d_st;

   nibble_serial_adder #(.NIBBLES(4)) dut (
      .clk       (clk),
      .rst       (d_rst),
      .in_valid  (d_iv),
      .in_ready  (d_ir),
      .x         (d_x),
      .y         (d_y),
      .c_in      (d_ci),
      .out_valid (d_ov),
      .out_ready (d_or),
      .sum       (d_s),
      .c_out     (d_co),
      .ovf       (d_of),
      .state_dbg (d_st)
   );

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic        c;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t vecs [9];

   // Called #1 after a rising edge with the DUT idle; returns once out_valid
   // is seen (or the bound expires) and reports the observed latency.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output int lat);
      chk("ready_before_accept", 64'(d_ir), 64'(1));
      d_iv = 1'b1;
      d_x  = a;
      d_y  = b;
      d_ci = c;
      d_or = 1'b0;
      @(posedge clk);
      #1;
      // Scramble the inputs: the captured operands must be the only ones used.
      d_iv = 1'b0;
      d_x  = 16'($urandom);
      d_y  = 16'($urandom);
      d_ci = 1'($urandom_range(0, 1));
      lat  = 0;
      while (!d_ov && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take_result();
      d_or = 1'b1;
      @(posedge clk);
      #1;
      d_or = 1'b0;
      chk("idle_after_take_valid", 64'(d_ov), 64'(0));
      chk("idle_after_take_ready", 64'(d_ir), 64'(1));
   endtask

   initial begin : directed
      int lat;
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[8] = '{16'h5A5A, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0};

      d_rst = 1'b1;
      d_iv  = 1'b0;
      d_or  = 1'b0;
      d_x   = '0;
      d_y   = '0;
      d_ci  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(d_ov), 64'(0));
      chk("reset_in_ready",  64'(d_ir), 64'(1));
      chk("reset_sum",       64'(d_s),  64'(0));
      chk("reset_c_out",     64'(d_co), 64'(0));
      chk("reset_ovf",       64'(d_of), 64'(0));
      chk("reset_state",     64'(d_st), 64'(ST_IDLE));
      // Released mid-cycle: the very next edge must accept.
      d_rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].x, vecs[i].y, vecs[i].c, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
         chk($sformatf("vec%0d_sum", i),     64'(d_s),  64'(vecs[i].s));
         chk($sformatf("vec%0d_c_out", i),   64'(d_co), 64'(vecs[i].co));
         chk($sformatf("vec%0d_ovf", i),     64'(d_of), 64'(vecs[i].ov));
         take_result();
      end

      // Back-pressure: result frozen, new operands ignored while DONE.
      do_op(16'h1234, 16'h4321, 1'b0, lat);
      chk("bp_latency", 64'(lat), 64'(4));
      for (int i = 0; i < 10; i++) begin
         d_iv = 1'b1;
         d_x  = 16'($urandom);
         d_y  = 16'($urandom);
         d_ci = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_sum", i),       64'(d_s),  64'(16'h5555));
         chk($sformatf("bp%0d_out_valid", i), 64'(d_ov), 64'(1));
         chk($sformatf("bp%0d_in_ready", i),  64'(d_ir), 64'(0));
      end
      d_iv = 1'b0;
      take_result();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_no_queued%0d", i), 64'(d_ov), 64'(0));
      end

      // Abort in the second RUN cycle.
      d_iv = 1'b1;
      d_x  = 16'h1234;
      d_y  = 16'h4321;
      d_ci = 1'b0;
      @(posedge clk);
      #1;
      d_iv = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_in_run", 64'(d_st), 64'(ST_RUN));
      d_rst = 1'b1;
      #1;
      chk("abort_out_valid", 64'(d_ov), 64'(0));
      chk("abort_in_ready",  64'(d_ir), 64'(1));
      chk("abort_sum",       64'(d_s),  64'(0));
      chk("abort_c_out",     64'(d_co), 64'(0));
      chk("abort_ovf",       64'(d_of), 64'(0));
      @(negedge clk);
      d_rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_no_result", 64'(d_ov), 64'(0));
      do_op(16'h0001, 16'h0001, 1'b0, lat);
      chk("after_abort_latency", 64'(lat), 64'(4));
      chk("after_abort_sum",     64'(d_s),  64'(16'h0002));
      chk("after_abort_c_out",   64'(d_co), 64'(0));
      take_result();

      wait (rand_fin == 3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // ---------------------------------------------------------------------------
   // Randomized traffic on NIBBLES = 2, 4, 8
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < 3; g++) begin : g_rand
      localparam int NN  = (g == 0) ? 2 : ((g == 1) ? 4 : 8);
      localparam int WW  = 4 * NN;
      localparam int OPS = (g == 0) ? 4000 : ((g == 1) ? 3000 : 2500);

      logic          rr, iv, ir, ov, orr, ci, co, of;
      logic [WW-1:0] xx, yy, ss;
      state_t        sd;
      logic [WW+1:0] exp_q[$];

      nibble_serial_adder #(.NIBBLES(NN)) dut_r (
         .clk       (clk),
         .rst       (rr),
         .in_valid  (iv),
         .in_ready  (ir),
         .x         (xx),
         .y         (yy),
         .c_in      (ci),
         .out_valid (ov),
         .out_ready (orr),
         .sum       (ss),
         .c_out     (co),
         .ovf       (of),
         .state_dbg (sd)
      );

      initial begin : stim
         int            accepts;
         int            results;
         int            cycles;
         logic [WW:0]   full;
         logic          ovf_e;

         accepts = 0;
         results = 0;
         cycles  = 0;
         rr  = 1'b1;
         iv  = 1'b0;
         orr = 1'b0;
         xx  = '0;
         yy  = '0;
         ci  = 1'b0;
         repeat (3) @(negedge clk);
         rr = 1'b0;

         // At each falling edge the DUT state is stable until the next rising
         // edge, so the handshakes that edge will perform are known as soon as
         // the new drive values are chosen.
         while (results < OPS && cycles < OPS * (NN + 1) * 3) begin
            @(negedge clk);
            cycles++;

            if (ov) begin
               if (exp_q.size() == 0) begin
                  chk($sformatf("rand_n%0d_spurious_result", NN), 64'(1), 64'(0));
               end else begin
                  chk($sformatf("rand_n%0d_result", NN), 64'({co, of, ss}), 64'(exp_q[0]));
               end
               chk($sformatf("rand_n%0d_ready_in_done", NN), 64'(ir), 64'(0));
            end

            orr = 1'($urandom_range(0, 1));
            if (ov && orr) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               results++;
            end

            iv = (accepts < OPS) ? 1'($urandom_range(0, 1)) : 1'b0;
            xx = WW'($urandom);
            yy = WW'($urandom);
            ci = 1'($urandom_range(0, 1));
            if (iv && ir) begin
               full  = {1'b0, xx} + {1'b0, yy} + (WW + 1)'(ci);
               ovf_e = (xx[WW-1] == yy[WW-1]) && (full[WW-1] != xx[WW-1]);
               exp_q.push_back({full[WW], ovf_e, full[WW-1:0]});
               accepts++;
            end
         end

         chk($sformatf("rand_n%0d_results_done", NN), 64'(results), 64'(OPS));
         chk($sformatf("rand_n%0d_queue_empty", NN), 64'(exp_q.size()), 64'(0));
         rand_fin++;
      end
   end

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
